// File: rtl/data_mem_copy_engine.sv
// Block-copy engine that borrows the data-memory port through a req/gnt
// handshake and moves word_count_i 32-bit words from src to dst.
// Each word takes one granted read cycle and then one granted write cycle.
// All memory-side outputs are zero unless the engine holds the grant, so
// they can be OR-muxed with the processor's own port signals.
`timescale 1ns/1ps
module data_mem_copy_engine #(
    parameter int DATA_WIDTH  = 32,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start_i,
    input  logic [DATA_WIDTH-1:0]  src_addr_i,
    input  logic [DATA_WIDTH-1:0]  dst_addr_i,
    input  logic [COUNT_WIDTH-1:0] word_count_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   mem_req_o,
    input  logic                   mem_gnt_i,
    output logic [DATA_WIDTH-1:0]  mem_address_o,
    output logic [DATA_WIDTH-1:0]  mem_write_data_o,
    output logic                   mem_write_o,
    output logic                   mem_read_o,
    input  logic [DATA_WIDTH-1:0]  mem_read_data_i,
    output logic [1:0]             fsm_state
);

    // Port handshake: mem_req_o is held high for as long as the engine has
    // an access pending (READ or WRITE). An access takes effect only in a
    // cycle where mem_gnt_i is also high. Without the grant, the engine
    // drives zeros and keeps its state, so it retries in the next cycle.
    // This means no access is ever lost or repeated.

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]             state;
    logic [DATA_WIDTH-1:0]  src;
    logic [DATA_WIDTH-1:0]  dst;
    logic [COUNT_WIDTH-1:0] count;
    logic [DATA_WIDTH-1:0]  buffer;

    assign fsm_state = state;

    // Sequencer: latch the job in IDLE, then alternate granted reads and
    // granted writes until the count runs out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            src    <= '0;
            dst    <= '0;
            count  <= '0;
            buffer <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        src   <= {src_addr_i[DATA_WIDTH-1:2], 2'b00};
                        dst   <= {dst_addr_i[DATA_WIDTH-1:2], 2'b00};
                        count <= word_count_i;
                        state <= (word_count_i == '0) ? DONE : READ;
                    end
                end
                READ: begin
                    if (mem_gnt_i) begin
                        buffer <= mem_read_data_i;
                        state  <= WRITE;
                    end
                end
                WRITE: begin
                    if (mem_gnt_i) begin
                        // Addresses wrap naturally modulo 2^DATA_WIDTH.
                        src <= src + DATA_WIDTH'(4);
                        dst <= dst + DATA_WIDTH'(4);
                        if (count != '0) begin
                            count <= count - COUNT_WIDTH'(1);
                        end
                        state <= (count == COUNT_WIDTH'(1)) ? DONE : READ;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Status outputs are decoded straight from the state.
    always_comb begin
        busy_o    = (state != IDLE);
        done_o    = (state == DONE);
        mem_req_o = (state == READ) || (state == WRITE);
    end

    // Memory-side outputs: nonzero only in a granted READ or WRITE cycle.
    always_comb begin
        mem_address_o    = '0;
        mem_write_data_o = '0;
        mem_write_o      = 1'b0;
        mem_read_o       = 1'b0;
        if (mem_gnt_i) begin
            if (state == READ) begin
                mem_read_o    = 1'b1;
                mem_address_o = src;
            end else if (state == WRITE) begin
                mem_write_o      = 1'b1;
                mem_address_o    = dst;
                mem_write_data_o = buffer;
            end
        end
    end

endmodule
